// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX shifter, RX sampler with 2-flop synchronizer,
// RX byte FIFO and a four-register bus interface with registered read data.
module uart_mmio #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_AW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS_N,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [11:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        UART_TXD,
  input  logic        UART_RXD
);

  localparam int DIV   = CLOCK_FREQ / BAUD_RATE;
  localparam int CW    = $clog2(DIV);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [CW-1:0]    BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]    HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

  localparam logic [1:0] REG_TX   = 2'd0;
  localparam logic [1:0] REG_RX   = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  // Bus decode: exactly one strobe low while selected.
  logic       rd_acc, wr_acc;
  logic [1:0] reg_sel;
  assign rd_acc  = !CS_N && !RD_N && WR_N;
  assign wr_acc  = !CS_N && !WR_N && RD_N;
  assign reg_sel = Addr[3:2];

  logic unused_bits;
  assign unused_bits = ^{Addr[11:4], Addr[1:0], DataIn[31:8]};

  // ---------------- TX ----------------
  uart_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_baud_q, tx_baud_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_sh_q, tx_sh_d;
  logic            tx_txd_q, tx_txd_d;
  logic            tx_busy, tx_start;

  assign tx_busy  = (tx_state_q != S_IDLE);
  assign tx_start = wr_acc && (reg_sel == REG_TX) && !tx_busy;
  assign UART_TXD = tx_txd_q;

  // TX next state: one bit-time per state (DATA repeats 8 times), LSB first.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_txd_d   = tx_txd_q;
    if (tx_state_q == S_IDLE) begin
      if (tx_start) begin
        tx_state_d = S_START;
        tx_baud_d  = BIT_LAST;
        tx_bit_d   = 3'd0;
        tx_sh_d    = DataIn[7:0];
        tx_txd_d   = 1'b0;
      end
    end else if (tx_baud_q != '0) begin
      tx_baud_d = tx_baud_q - 1'b1;
    end else begin
      tx_baud_d = BIT_LAST;
      case (tx_state_q)
        S_START: begin
          tx_state_d = S_DATA;
          tx_txd_d   = tx_sh_q[0];
          tx_sh_d    = tx_sh_q >> 1;
        end
        S_DATA: begin
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_txd_d   = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_txd_d = tx_sh_q[0];
            tx_sh_d  = tx_sh_q >> 1;
          end
        end
        default: begin
          tx_state_d = S_IDLE;
          tx_txd_d   = 1'b1;
        end
      endcase
    end
  end

  // TX state register; reset drives the line idle-high immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_txd_q   <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_txd_q   <= tx_txd_d;
    end
  end

  // ---------------- RX ----------------
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  uart_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_baud_q, rx_baud_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            rx_push, rx_ferr;

  // RX next state: half bit-time to the start-bit center, then full bit-times.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
    if (rx_state_q == S_IDLE) begin
      if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = S_START;
        rx_baud_d  = HALF_LAST;
      end
    end else if (rx_baud_q != '0) begin
      rx_baud_d = rx_baud_q - 1'b1;
    end else begin
      rx_baud_d = BIT_LAST;
      case (rx_state_q)
        S_START: begin
          if (rx_s2_q) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_state_d = S_DATA;
            rx_bit_d   = 3'd0;
          end
        end
        S_DATA: begin
          rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end
        default: begin
          rx_push    = rx_s2_q;
          rx_ferr    = !rx_s2_q;
          rx_state_d = S_IDLE;
        end
      endcase
    end
  end

  // RX synchronizer, edge-detect history and state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_s1_q    <= UART_RXD;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  // ---------------- FIFO and flags ----------------
  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               fifo_full, fifo_nempty, push_ok, pop;
  logic               overflow_q, frame_err_q, ctrl_wr;

  assign fifo_full   = (count_q == FULL_CNT);
  assign fifo_nempty = (count_q != '0);
  assign push_ok     = rx_push && !fifo_full;
  assign pop         = rd_acc && (reg_sel == REG_RX) && fifo_nempty;
  assign ctrl_wr     = wr_acc && (reg_sel == REG_CTRL);

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the count gates every read, so stale contents are never visible.
    if (push_ok) fifo_mem[wr_ptr_q] <= rx_sh_q;
  end

  // FIFO pointers, occupancy and sticky flags (a set in the same cycle wins over a clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (rx_push && fifo_full)      overflow_q  <= 1'b1;
      else if (ctrl_wr && DataIn[0]) overflow_q  <= 1'b0;
      if (rx_ferr)                   frame_err_q <= 1'b1;
      else if (ctrl_wr && DataIn[1]) frame_err_q <= 1'b0;
    end
  end

  // ---------------- Read path ----------------
  logic [31:0] rd_data, data_out_q;

  // Read mux for the addressed register.
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_TX: rd_data[0] = tx_busy;
      REG_RX: if (fifo_nempty) rd_data[7:0] = fifo_mem[rd_ptr_q];
      REG_STAT: begin
        rd_data[8 +: FIFO_AW+1] = count_q;
        rd_data[4] = frame_err_q;
        rd_data[3] = overflow_q;
        rd_data[2] = fifo_full;
        rd_data[1] = fifo_nempty;
        rd_data[0] = tx_busy;
      end
      default: rd_data = '0;
    endcase
  end

  // Registered read data, held until the next accepted read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       data_out_q <= '0;
    else if (rd_acc) data_out_q <= rd_data;
  end

  assign DataOut = data_out_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio with DIV = 16: directed steps plus random
// bytes, checked against a queue-based model of the FIFO and sticky flags.
module tb_uart_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        CS_N, RD_N, WR_N;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        UART_TXD;
  logic        UART_RXD;

  int checks = 0;
  int errors = 0;

  // Reference model: received-byte queue and sticky flags.
  logic [7:0] model_q [$];
  logic       m_ovf = 1'b0;
  logic       m_ferr = 1'b0;

  uart_mmio #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .FIFO_AW(3)) dut (
    .clk(clk), .reset(reset), .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
    .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut),
    .UART_TXD(UART_TXD), .UART_RXD(UART_RXD)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int n;
    n = model_q.size();
    return (32'(n) << 8) | (32'(m_ferr) << 4) | (32'(m_ovf) << 3)
         | (32'(n == 8) << 2) | (32'(n != 0) << 1);
  endfunction

  // Line level expected k clocks after a frame of byte b started.
  function automatic logic tx_exp(input logic [7:0] b, input int k);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    if (k >= 160) return 1'b1;
    return fr[k / 16];
  endfunction

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk);
    CS_N = 1'b0; RD_N = 1'b0; Addr = a;
    @(negedge clk);
    CS_N = 1'b1; RD_N = 1'b1;
    d = DataOut;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    CS_N = 1'b0; WR_N = 1'b0; Addr = a; DataIn = d;
    @(negedge clk);
    CS_N = 1'b1; WR_N = 1'b1;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    bus_read(12'h008, d);
    check(tag, d, exp_status());
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    bus_read(12'h004, d);
    e = (model_q.size() != 0) ? {24'b0, model_q.pop_front()} : 32'h0;
    check(tag, d, e);
  endtask

  // Drive one serial frame into UART_RXD and update the model.
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      UART_RXD = fr[i];
      repeat (16) @(negedge clk);
    end
    UART_RXD = 1'b1;
    repeat (6) @(negedge clk);
    if (!stop)                    m_ferr = 1'b1;
    else if (model_q.size() == 8) m_ovf  = 1'b1;
    else                          model_q.push_back(b);
  endtask

  // Start a TX frame and check the line every clock plus tx_busy at its boundaries.
  task automatic tx_frame(input string tag, input logic [7:0] b, input logic overwrite);
    int bad;
    logic pending;
    logic [31:0] pend_exp;
    bad = 0;
    pending = 1'b0;
    pend_exp = 32'h0;
    @(negedge clk);
    CS_N = 1'b0; WR_N = 1'b0; Addr = 12'h000; DataIn = {24'b0, b};
    @(negedge clk);
    for (int k = 0; k < 176; k++) begin
      if (UART_TXD !== tx_exp(b, k)) bad++;
      if (pending) begin
        check({tag, "_busy"}, DataOut, pend_exp);
        pending = 1'b0;
      end
      CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
      if (k == 2 || k == 159 || k == 160) begin
        CS_N = 1'b0; RD_N = 1'b0; Addr = 12'h000;
        pending = 1'b1;
        pend_exp = {31'b0, (k < 160)};
      end
      if (overwrite && k == 50) begin
        CS_N = 1'b0; WR_N = 1'b0; Addr = 12'h000; DataIn = 32'h0000_00AA;
      end
      @(negedge clk);
    end
    CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
    check({tag, "_wave_errs"}, 32'(bad), 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    int n;

    reset = 1'b1; CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
    Addr = '0; DataIn = '0; UART_RXD = 1'b1;
    #1;
    check("reset_txd", {31'b0, UART_TXD}, 32'h1);
    check("reset_dataout", DataOut, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_status("reset_status");
    read_rx("empty_read");

    // TX of 0x55, with a second write of 0xAA while busy that must be ignored.
    tx_frame("tx_55", 8'h55, 1'b1);
    b = 8'($urandom);
    tx_frame("tx_rand", b, 1'b0);

    // RX of 0xA5: STATUS 0x102, then byte, then empty STATUS.
    rx_frame(8'hA5, 1'b1);
    check("status_a5_literal", exp_status(), 32'h0000_0102);
    check_status("status_a5");
    read_rx("rx_a5");
    check_status("status_after_pop");

    // Spurious start: a short low pulse must not produce a byte.
    @(negedge clk);
    UART_RXD = 1'b0;
    repeat (4) @(negedge clk);
    UART_RXD = 1'b1;
    repeat (40) @(negedge clk);
    check_status("status_spurious");

    // Random burst of bytes, drained through the FIFO.
    n = int'($urandom_range(2, 5));
    for (int i = 0; i < n; i++) rx_frame(8'($urandom), 1'b1);
    check_status("status_rand");
    for (int i = 0; i <= n; i++) read_rx("rx_rand");

    // Overflow: nine bytes into an eight-deep FIFO.
    for (int i = 1; i <= 9; i++) rx_frame(8'(i), 1'b1);
    check_status("status_overflow");
    for (int i = 0; i < 9; i++) read_rx("rx_ovf_drain");
    bus_write(12'h00C, 32'h1);
    m_ovf = 1'b0;
    check_status("status_ovf_cleared");

    // Framing error on 0x3C, then cleared through CTRL.
    rx_frame(8'h3C, 1'b0);
    check_status("status_frame_err");
    bus_write(12'h00C, 32'h2);
    m_ferr = 1'b0;
    check_status("status_ferr_cleared");
    bus_read(12'h00C, d);
    check("ctrl_read", d, 32'h0);

    // Reset in the middle of a TX frame with a byte pending in the FIFO.
    rx_frame(8'($urandom), 1'b1);
    bus_write(12'h000, 32'h0000_00F0);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_txd", {31'b0, UART_TXD}, 32'h1);
    check("midreset_dataout", DataOut, 32'h0);
    model_q.delete();
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_read(12'h000, d);
    check("midreset_busy", d, 32'h0);
    check_status("midreset_status");
    b = 8'($urandom);
    tx_frame("tx_after_reset", b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
